reg_file_wb_arbiter: RTL and testbench

// - Shares the Register_File's single write port between two writeback requesters: port 0 (ALU) and port 1 (load unit).
// - Holds a 32-entry pending scoreboard, so decode can stall on registers whose writeback is still in flight.
// - Sits between the execute/memory stages and Register_File. It drives Reg_Write_i, Write_Register_i and Write_Data_i.

---
 rtl/reg_file_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_reg_file_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb_arbiter.sv
// reg_file_wb_arbiter
// Shares the Register_File write port between the ALU (port 0) and the load
// unit (port 1). It also keeps a pending-write scoreboard that decode queries
// for hazards.
// Optional feature macro: RF_WB_BYPASS_EN adds forwarding outputs. With it,
// a register written this cycle is not reported busy.
module reg_file_wb_arbiter #(
  parameter int N          = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb0_valid_i,
  input  logic [4:0]   wb0_addr_i,
  input  logic [N-1:0] wb0_data_i,
  output logic         wb0_ready_o,
  input  logic         wb1_valid_i,
  input  logic [4:0]   wb1_addr_i,
  input  logic [N-1:0] wb1_data_i,
  output logic         wb1_ready_o,
  input  logic         pend_set_i,
  input  logic [4:0]   pend_addr_i,
  input  logic [4:0]   rs1_addr_i,
  input  logic [4:0]   rs2_addr_i,
  output logic         rs1_busy_o,
  output logic         rs2_busy_o,
`ifdef RF_WB_BYPASS_EN
  output logic         rs1_fwd_o,
  output logic         rs2_fwd_o,
  output logic [N-1:0] rs1_fwd_data_o,
  output logic [N-1:0] rs2_fwd_data_o,
`endif
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o
);

  logic         last_grant_q, last_grant_d;
  logic         reg_write_q, reg_write_d;
  logic [4:0]   write_register_q, write_register_d;
  logic [N-1:0] write_data_q, write_data_d;
  logic [31:0]  pend_q, pend_d;

  logic         grant0, grant1, conflict;
  logic [4:0]   sel_addr;
  logic [N-1:0] sel_data;
  logic         rs1_fwd, rs2_fwd;

  // Pick one requester per cycle.
  // last_grant_q=1 means port 1 won the previous conflict, so port 0 is next.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    conflict = wb0_valid_i && wb1_valid_i;
    if (!reset) begin
      if (conflict) begin
        if (FIXED_PRIO != 0 || last_grant_q) grant0 = 1'b1;
        else                                 grant1 = 1'b1;
      end else if (wb0_valid_i) begin
        grant0 = 1'b1;
      end else if (wb1_valid_i) begin
        grant1 = 1'b1;
      end
    end
  end

  // Round-robin pointer.
  // It moves only when both ports compete, so a lone requester does not disturb fairness.
  always_comb begin
    last_grant_d = last_grant_q;
    if (reset)         last_grant_d = 1'b1;
    else if (conflict) last_grant_d = grant1;
  end

  // Writeback register stage.
  // An accepted x0 write still loads addr/data, but it never asserts Reg_Write_o.
  always_comb begin
    sel_addr         = grant1 ? wb1_addr_i : wb0_addr_i;
    sel_data         = grant1 ? wb1_data_i : wb0_data_i;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (reset) begin
      write_register_d = '0;
      write_data_d     = '0;
    end else if (grant0 || grant1) begin
      reg_write_d      = (sel_addr != 5'd0);
      write_register_d = sel_addr;
      write_data_d     = sel_data;
    end
  end

  // Scoreboard update.
  // The clear comes first so that a same-cycle set of the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (reg_write_q) pend_d[write_register_q] = 1'b0;
    if (pend_set_i && pend_addr_i != 5'd0) pend_d[pend_addr_i] = 1'b1;
    if (reset) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  // State registers with synchronous reset folded into the next-state logic.
  always_ff @(posedge clk) begin
    last_grant_q     <= last_grant_d;
    reg_write_q      <= reg_write_d;
    write_register_q <= write_register_d;
    write_data_q     <= write_data_d;
    pend_q           <= pend_d;
  end

`ifdef RF_WB_BYPASS_EN
  // Forward the register being written this cycle so decode can skip the stall.
  always_comb begin
    rs1_fwd        = reg_write_q && (write_register_q == rs1_addr_i) && (rs1_addr_i != 5'd0);
    rs2_fwd        = reg_write_q && (write_register_q == rs2_addr_i) && (rs2_addr_i != 5'd0);
    rs1_fwd_o      = rs1_fwd;
    rs2_fwd_o      = rs2_fwd;
    rs1_fwd_data_o = write_data_q;
    rs2_fwd_data_o = write_data_q;
  end
`else
  // Without forwarding, a register stays busy through its write cycle.
  always_comb begin
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
  end
`endif

  // Handshake and hazard outputs.
  // Busy reads only the registered scoreboard and is suppressed during reset.
  always_comb begin
    wb0_ready_o      = grant0;
    wb1_ready_o      = grant1;
    rs1_busy_o       = !reset && pend_q[rs1_addr_i] && !rs1_fwd;
    rs2_busy_o       = !reset && pend_q[rs2_addr_i] && !rs2_fwd;
    Reg_Write_o      = reg_write_q;
    Write_Register_o = write_register_q;
    Write_Data_o     = write_data_q;
  end

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// tb_reg_file_wb_arbiter
// Directed vectors for the writeback arbiter.
// A round-robin instance and a fixed-priority instance share the same inputs.
// Build with RF_WB_BYPASS_EN defined to cover the forwarding outputs.
`timescale 1ns/1ps
module tb_reg_file_wb_arbiter;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wb0_valid, wb1_valid, pend_set;
  logic [4:0]  wb0_addr, wb1_addr, pend_addr, rs1_addr, rs2_addr;
  logic [31:0] wb0_data, wb1_data;

  logic        rdy0, rdy1, busy1, busy2, rw;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic        fp_rdy0, fp_rdy1, fp_busy1, fp_busy2, fp_rw;
  logic [4:0]  fp_wr;
  logic [31:0] fp_wd;
`ifdef RF_WB_BYPASS_EN
  logic        fwd1, fwd2, fp_fwd1, fp_fwd2;
  logic [31:0] fwd_d1, fwd_d2, fp_fwd_d1, fp_fwd_d2;
`endif

  int n_compared;
  int n_mismatched;

  reg_file_wb_arbiter #(.N(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid_i(wb0_valid), .wb0_addr_i(wb0_addr), .wb0_data_i(wb0_data), .wb0_ready_o(rdy0),
    .wb1_valid_i(wb1_valid), .wb1_addr_i(wb1_addr), .wb1_data_i(wb1_data), .wb1_ready_o(rdy1),
    .pend_set_i(pend_set), .pend_addr_i(pend_addr),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_busy_o(busy1), .rs2_busy_o(busy2),
`ifdef RF_WB_BYPASS_EN
    .rs1_fwd_o(fwd1), .rs2_fwd_o(fwd2), .rs1_fwd_data_o(fwd_d1), .rs2_fwd_data_o(fwd_d2),
`endif
    .Reg_Write_o(rw), .Write_Register_o(wr), .Write_Data_o(wd)
  );

  reg_file_wb_arbiter #(.N(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .wb0_valid_i(wb0_valid), .wb0_addr_i(wb0_addr), .wb0_data_i(wb0_data), .wb0_ready_o(fp_rdy0),
    .wb1_valid_i(wb1_valid), .wb1_addr_i(wb1_addr), .wb1_data_i(wb1_data), .wb1_ready_o(fp_rdy1),
    .pend_set_i(pend_set), .pend_addr_i(pend_addr),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_busy_o(fp_busy1), .rs2_busy_o(fp_busy2),
`ifdef RF_WB_BYPASS_EN
    .rs1_fwd_o(fp_fwd1), .rs2_fwd_o(fp_fwd2), .rs1_fwd_data_o(fp_fwd_d1), .rs2_fwd_data_o(fp_fwd_d2),
`endif
    .Reg_Write_o(fp_rw), .Write_Register_o(fp_wr), .Write_Data_o(fp_wd)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ps;
    logic [4:0]  pa;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_b1;
    logic        e_b2;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        chk_wb;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic ps, input logic [4:0] pa,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic e_rdy0, input logic e_rdy1,
                              input logic e_b1, input logic e_b2, input logic e_rw,
                              input logic [4:0] e_wr, input logic [31:0] e_wd, input logic chk_wb);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.ps = ps; v.pa = pa; v.r1 = r1; v.r2 = r2;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd; v.chk_wb = chk_wb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wb0_valid = v.v0; wb0_addr = v.a0; wb0_data = v.d0;
    wb1_valid = v.v1; wb1_addr = v.a1; wb1_data = v.d1;
    pend_set  = v.ps; pend_addr = v.pa;
    rs1_addr  = v.r1; rs2_addr = v.r2;
  endtask

  task automatic checkRow(input int i, input vec_t v);
    checkOutput($sformatf("row%0d wb0_ready", i), {31'd0, rdy0}, {31'd0, v.e_rdy0});
    checkOutput($sformatf("row%0d wb1_ready", i), {31'd0, rdy1}, {31'd0, v.e_rdy1});
    checkOutput($sformatf("row%0d rs1_busy", i), {31'd0, busy1}, {31'd0, v.e_b1});
    checkOutput($sformatf("row%0d rs2_busy", i), {31'd0, busy2}, {31'd0, v.e_b2});
    checkOutput($sformatf("row%0d Reg_Write", i), {31'd0, rw}, {31'd0, v.e_rw});
    if (v.chk_wb) begin
      checkOutput($sformatf("row%0d Write_Register", i), {27'd0, wr}, {27'd0, v.e_wr});
      checkOutput($sformatf("row%0d Write_Data", i), wd, v.e_wd);
    end
`ifdef RF_WB_BYPASS_EN
    begin
      logic ef1, ef2;
      ef1 = v.e_rw && (v.e_wr == v.r1) && (v.r1 != 5'd0);
      ef2 = v.e_rw && (v.e_wr == v.r2) && (v.r2 != 5'd0);
      checkOutput($sformatf("row%0d rs1_fwd", i), {31'd0, fwd1}, {31'd0, ef1});
      checkOutput($sformatf("row%0d rs2_fwd", i), {31'd0, fwd2}, {31'd0, ef2});
      if (ef1) checkOutput($sformatf("row%0d rs1_fwd_data", i), fwd_d1, v.e_wd);
      if (ef2) checkOutput($sformatf("row%0d rs2_fwd_data", i), fwd_d2, v.e_wd);
    end
`endif
  endtask

  // Main sequence
  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    //              v0 a0     d0            v1 a1     d1            ps pa     r1     r2      rdy0 rdy1 b1    b2 rw wr     wd            chk
    tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  1, 0, 0,    0, 0, 5'd0,  32'h0,        1);
    tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  0, 0, 0,    0, 1, 5'd5,  32'hDEADBEEF, 1);
    tbl[2]  = mk(1, 5'd6,  32'h66660000, 1, 5'd7,  32'h77770000, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0,    0, 0, 5'd5,  32'hDEADBEEF, 1);
    tbl[3]  = mk(1, 5'd6,  32'h66660000, 1, 5'd7,  32'h77770000, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0,    0, 1, 5'd6,  32'h66660000, 1);
    tbl[4]  = mk(1, 5'd6,  32'h66660000, 1, 5'd7,  32'h77770000, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0,    0, 1, 5'd7,  32'h77770000, 1);
    tbl[5]  = mk(1, 5'd6,  32'h66660000, 1, 5'd7,  32'h77770000, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0,    0, 1, 5'd6,  32'h66660000, 1);
    tbl[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  0, 0, 0,    0, 1, 5'd7,  32'h77770000, 1);
    tbl[7]  = mk(1, 5'd3,  32'h00000033, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  1, 0, 0,    0, 0, 5'd7,  32'h77770000, 1);
    tbl[8]  = mk(1, 5'd4,  32'h00000044, 1, 5'd8,  32'h00000088, 0, 5'd0,  5'd0,  5'd0,  1, 0, 0,    0, 1, 5'd3,  32'h00000033, 1);
    tbl[9]  = mk(1, 5'd4,  32'h00000044, 1, 5'd8,  32'h00000088, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0,    0, 1, 5'd4,  32'h00000044, 1);
    tbl[10] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  0, 0, 0,    0, 1, 5'd8,  32'h00000088, 1);
    tbl[11] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd0,  0, 0, 0,    0, 0, 5'd8,  32'h00000088, 1);
    tbl[12] = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h00000099, 0, 5'd0,  5'd9,  5'd0,  0, 1, 1,    0, 0, 5'd8,  32'h00000088, 1);
    tbl[13] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd0,  0, 0, !BYP, 0, 1, 5'd9,  32'h00000099, 1);
    tbl[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd0,  0, 0, 1,    0, 0, 5'd9,  32'h00000099, 1);
    tbl[15] = mk(1, 5'd9,  32'h00000999, 0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd0,  1, 0, 1,    0, 0, 5'd9,  32'h00000099, 1);
    tbl[16] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd0,  0, 0, !BYP, 0, 1, 5'd9,  32'h00000999, 1);
    tbl[17] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd0,  0, 0, 0,    0, 0, 5'd9,  32'h00000999, 1);
    tbl[18] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  5'd0,  0, 0, 0,    0, 0, 5'd9,  32'h00000999, 1);
    tbl[19] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd9,  0, 0, 0,    0, 0, 5'd9,  32'h00000999, 1);
    tbl[20] = mk(1, 5'd0,  32'h0000ABCD, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  1, 0, 0,    0, 0, 5'd9,  32'h00000999, 1);
    tbl[21] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd0,  0, 0, 0,    0, 0, 5'd0,  32'h0,        0);
    tbl[22] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd12, 5'd0,  5'd0,  0, 0, 0,    0, 0, 5'd0,  32'h0,        0);
    tbl[23] = mk(1, 5'd12, 32'hC0FFEE12, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd12, 1, 0, 0,    1, 0, 5'd0,  32'h0,        0);
    tbl[24] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd12, 0, 0, 0, !BYP, 1, 5'd12, 32'hC0FFEE12, 1);
    tbl[25] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd12, 0, 0, 0,    0, 0, 5'd12, 32'hC0FFEE12, 1);

    // Reset with both requesters asserting: nothing may be accepted
    reset = 1'b1;
    applyStimulus(mk(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd3, 5'd0, 5'd0,
                     0, 0, 0, 0, 0, 5'd0, 32'h0, 0));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("reset%0d wb0_ready", c), {31'd0, rdy0}, 32'd0);
      checkOutput($sformatf("reset%0d wb1_ready", c), {31'd0, rdy1}, 32'd0);
      checkOutput($sformatf("reset%0d Reg_Write", c), {31'd0, rw}, 32'd0);
      checkOutput($sformatf("reset%0d Write_Register", c), {27'd0, wr}, 32'd0);
      checkOutput($sformatf("reset%0d Write_Data", c), wd, 32'd0);
      if (c == 1) begin
        for (int a = 0; a < 32; a++) begin
          rs1_addr = a[4:0];
          #0.1;
          checkOutput($sformatf("reset rs1_busy x%0d", a), {31'd0, busy1}, 32'd0);
        end
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Table-driven cycles, with the first row applied at reset release
    for (int i = 0; i < 26; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkRow(i, tbl[i]);
    end

    // Fixed priority: port 1 starves while port 0 stays valid
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(mk(c < 3, 5'd20, 32'h00000A20, c < 4, 5'd21, 32'h00000B21,
                       0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 0));
      @(negedge clk);
      checkOutput($sformatf("fp%0d wb0_ready", c), {31'd0, fp_rdy0}, {31'd0, c < 3});
      checkOutput($sformatf("fp%0d wb1_ready", c), {31'd0, fp_rdy1}, {31'd0, c == 3});
      checkOutput($sformatf("fp%0d busy", c), {30'd0, fp_busy1, fp_busy2}, 32'd0);
`ifdef RF_WB_BYPASS_EN
      checkOutput($sformatf("fp%0d fwd", c), {30'd0, fp_fwd1, fp_fwd2}, 32'd0);
      if (fp_fwd1 || fp_fwd2)
        checkOutput($sformatf("fp%0d fwd_data", c), fp_fwd_d1 ^ fp_fwd_d2, 32'd0);
`endif
      if (c >= 1) begin
        checkOutput($sformatf("fp%0d Reg_Write", c), {31'd0, fp_rw}, 32'd1);
        checkOutput($sformatf("fp%0d Write_Register", c), {27'd0, fp_wr}, (c == 4) ? 32'd21 : 32'd20);
        checkOutput($sformatf("fp%0d Write_Data", c), fp_wd, (c == 4) ? 32'h00000B21 : 32'h00000A20);
      end
    end

    // Reset in the middle of traffic drops pending state and the in-flight write
    @(posedge clk);
    #1;
    applyStimulus(mk(1, 5'd15, 32'h00000F15, 0, 5'd0, 32'h0, 1, 5'd15, 5'd0, 5'd0,
                     0, 0, 0, 0, 0, 5'd0, 32'h0, 0));
    @(negedge clk);
    checkOutput("midrst accept", {31'd0, rdy0}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(mk(1, 5'd16, 32'h00000F16, 0, 5'd0, 32'h0, 0, 5'd0, 5'd15, 5'd0,
                     0, 0, 0, 0, 0, 5'd0, 32'h0, 0));
    @(negedge clk);
    checkOutput("midrst wb0_ready", {31'd0, rdy0}, 32'd0);
    checkOutput("midrst rs1_busy", {31'd0, busy1}, 32'd0);
    checkOutput("midrst Reg_Write before edge", {31'd0, rw}, 32'd1);
    checkOutput("midrst Write_Register before edge", {27'd0, wr}, 32'd15);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd15, 5'd0,
                     0, 0, 0, 0, 0, 5'd0, 32'h0, 0));
    @(negedge clk);
    checkOutput("postrst Reg_Write", {31'd0, rw}, 32'd0);
    checkOutput("postrst Write_Register", {27'd0, wr}, 32'd0);
    checkOutput("postrst Write_Data", wd, 32'd0);
    checkOutput("postrst rs1_busy", {31'd0, busy1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
